rr_arbiter_slice_param: RTL and testbench

Parametrised round-robin arbiter with per-requester programmable time slices and a grant-lock option. N requesters contend for one shared resource. The winner holds a registered one-hot grant for up to its own slice length, then priority rotates to the next requester. It is the generalised successor of the fixed 4-requester variable-time-slice arbiter and drops into the same request/grant fabric.

---
 rtl/rr_arbiter_slice_param_if.sv | 24 ++
 rtl/rr_arbiter_slice_param.sv | 79 +++++++
 tb/tb_rr_arbiter_slice_param.sv | 111 +++++++++++
 3 files changed

// File: rtl/rr_arbiter_slice_param_if.sv
// rr_arbiter_slice_param_if: request/grant bundle between requesters and the arbiter
// Signals:
//   req       N          level requests, bit i = requester i
//   slice     N*SLICE_W  per-requester slice length, field i = slice[i*SLICE_W +: SLICE_W]
//   lock      1          hold the current grant past slice expiry
//   gnt       N          registered one-hot grant (or zero)
//   gnt_id    IDW        index of the current grantee, holds while gnt_valid=0
//   gnt_valid 1          |gnt
// Modports: master = requester side, slave = arbiter side.
interface rr_arbiter_slice_param_if #(
    parameter int N       = 4,
    parameter int SLICE_W = 4,
    parameter int IDW     = $clog2(N)
);
    logic [N-1:0]         req;
    logic [N*SLICE_W-1:0] slice;
    logic                 lock;
    logic [N-1:0]         gnt;
    logic [IDW-1:0]       gnt_id;
    logic                 gnt_valid;

    modport master (output req, slice, lock, input gnt, gnt_id, gnt_valid);
    modport slave  (input req, slice, lock, output gnt, gnt_id, gnt_valid);
endinterface

// File: rtl/rr_arbiter_slice_param.sv
// rr_arbiter_slice_param: round-robin arbiter with per-requester time slices and grant lock
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  slave side of rr_arbiter_slice_param_if (req/slice/lock in, gnt/gnt_id/gnt_valid out)
module rr_arbiter_slice_param #(
    parameter int N       = 4,
    parameter int SLICE_W = 4,
    parameter int IDW     = $clog2(N)
) (
    input logic clk,
    input logic rst,
    rr_arbiter_slice_param_if.slave bus
);
    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state;
    logic [IDW-1:0]     ptr;
    logic [SLICE_W-1:0] cnt;
    logic [SLICE_W-1:0] cur_slice;
    logic [N-1:0]       gnt;
    logic [IDW-1:0]     gnt_id;

    logic [IDW-1:0]     win;
    logic               any;
    int                 idx;
    logic [SLICE_W-1:0] win_slice;
    logic               at_end;
    logic               rel;

    // ptr always points one past the last winner, so the same search serves
    // both the idle load and the back-to-back reload on release.
    always_comb begin
        win = '0;
        any = 1'b0;
        idx = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!any && bus.req[idx]) begin
                any = 1'b1;
                win = IDW'(idx);
            end
        end
    end

    assign win_slice = bus.slice[int'(win)*SLICE_W +: SLICE_W];
    assign at_end    = cnt == cur_slice - SLICE_W'(1);
    assign rel       = state == IDLE || !bus.req[gnt_id] || (at_end && !bus.lock);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            cnt       <= '0;
            cur_slice <= SLICE_W'(1);
            gnt       <= '0;
            gnt_id    <= '0;
        end else if (rel) begin
            if (any) begin
                state     <= GRANT;
                gnt       <= N'(1) << win;
                gnt_id    <= win;
                cnt       <= '0;
                cur_slice <= win_slice == '0 ? SLICE_W'(1) : win_slice;
                ptr       <= int'(win) == N - 1 ? '0 : win + IDW'(1);
            end else begin
                state <= IDLE;
                gnt   <= '0;
            end
        end else begin
            cnt <= at_end ? cnt : cnt + SLICE_W'(1);
        end
    end

    assign bus.gnt       = gnt;
    assign bus.gnt_id    = gnt_id;
    assign bus.gnt_valid = |gnt;
endmodule

// File: tb/tb_rr_arbiter_slice_param.sv
// tb_rr_arbiter_slice_param: directed and randomized check against a behavioural grant model
module tb_rr_arbiter_slice_param;
    localparam int N   = 4;
    localparam int SW  = 4;
    localparam int IDW = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rr_arbiter_slice_param_if #(.N(N), .SLICE_W(SW), .IDW(IDW)) bus ();
    rr_arbiter_slice_param #(.N(N), .SLICE_W(SW), .IDW(IDW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_chk = 0;
    int n_fail = 0;

    // model: owner = current grantee (-1 none), held = cycles granted so far
    int owner, held, len, mptr, mid;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model();
        int w, s;
        if (rst) begin
            owner = -1; mptr = 0; mid = 0; held = 0;
        end else if (owner < 0 || !bus.req[owner] || (held >= len && !bus.lock)) begin
            w = -1;
            for (int k = 0; k < N; k++)
                if (w < 0 && bus.req[(mptr + k) % N]) w = (mptr + k) % N;
            if (w >= 0) begin
                s = int'(bus.slice[w*SW +: SW]);
                owner = w; mid = w; held = 1; len = s == 0 ? 1 : s; mptr = (w + 1) % N;
            end else owner = -1;
        end else held++;
    endtask

    task automatic step();
        @(posedge clk);
        model();
        #1;
        chk("gnt", 32'(bus.gnt), owner < 0 ? 32'd0 : 32'd1 << owner);
        chk("gnt_id", 32'(bus.gnt_id), 32'(mid));
        chk("gnt_valid", 32'(bus.gnt_valid), 32'(owner >= 0));
    endtask

    task automatic drive(input logic r, input logic [N-1:0] q, input logic [N*SW-1:0] s, input logic l);
        rst = r; bus.req = q; bus.slice = s; bus.lock = l;
    endtask

    logic [N-1:0] rot [9] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001};

    initial begin
        owner = -1; held = 0; len = 1; mptr = 0; mid = 0;
        // reset with all requesting, then full rotation with slices of 2
        drive(1, 4'b1111, 16'h2222, 0);
        repeat (2) begin step(); chk("rst_gnt", 32'(bus.gnt), 0); end
        rst = 0;
        for (int i = 0; i < 9; i++) begin step(); chk("rotation", 32'(bus.gnt), 32'(rot[i])); end
        // sole requester, slice 3 then slice 0
        drive(0, 4'b0100, 16'h0300, 0);
        repeat (7) step();
        chk("sole", 32'(bus.gnt), 32'b0100);
        bus.slice = 16'h0000;
        repeat (5) step();
        chk("sole_zero", 32'(bus.gnt), 32'b0100);
        // early release: requester 0 with slice 5 drops after 2 cycles
        drive(1, 4'b0011, 16'h0035, 0);
        step(); rst = 0;
        repeat (2) step();
        chk("early_hold", 32'(bus.gnt), 32'b0001);
        bus.req = 4'b0010;
        step();
        chk("early_next", 32'(bus.gnt), 32'b0010);
        repeat (4) step();
        // lock on a slice of 1
        drive(1, 4'b0011, 16'h0021, 1);
        step(); rst = 0;
        repeat (6) step();
        chk("lock_hold", 32'(bus.gnt), 32'b0001);
        bus.lock = 0;
        step();
        chk("lock_release", 32'(bus.gnt), 32'b0010);
        // reset mid-grant then requesters 1 and 3
        drive(1, 4'b1000, 16'h0030, 0);
        step(); rst = 0;
        repeat (2) step();
        rst = 1; step();
        chk("rst_mid", 32'(bus.gnt), 0);
        drive(0, 4'b1010, 16'h0030, 0);
        step();
        chk("after_rst", 32'(bus.gnt), 32'b0010);
        repeat (3) step();
        chk("after_rst2", 32'(bus.gnt), 32'b1000);
        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++) if ($urandom_range(7) == 0) bus.req[b] = ~bus.req[b];
            if ($urandom_range(15) == 0) bus.slice = 16'($urandom);
            if ($urandom_range(9) == 0) bus.lock = ~bus.lock;
            rst = $urandom_range(199) == 0;
            step();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
